// File: rtl/bsg_credit_to_token_pacer.sv
// Credit-to-token pacer: decimates returned credits into tokens and launches each
// token as a registered pulse with bounded high/low phases on token_o.
module bsg_credit_to_token_pacer
  #(parameter int lg_credit_to_token_decimation_p = 3
   ,parameter int max_credits_p                   = 64
   ,parameter int extra_tokens_p                  = 0
   ,parameter int min_half_period_p               = 2
   ,localparam int max_tokens_lp = (max_credits_p >> lg_credit_to_token_decimation_p) + extra_tokens_p
   ,localparam int ptr_width_lp  = $clog2(max_tokens_lp + 1)
   )
   (input  logic                    clk_i
   ,input  logic                    reset_i
   ,input  logic                    credit_v_i
   ,output logic                    token_o
   ,output logic [ptr_width_lp-1:0] tokens_pending_o
   ,output logic                    overflow_o
   );

   localparam int cnt_width_lp = $clog2(min_half_period_p + 1);

   localparam logic [1:0] idle_s = 2'd0;
   localparam logic [1:0] high_s = 2'd1;
   localparam logic [1:0] low_s  = 2'd2;

   logic [1:0]              state_r;
   logic [cnt_width_lp-1:0] cnt_r;
   logic [ptr_width_lp-1:0] pend_r;
   logic                    token_r;
   logic                    overflow_r;
   logic                    complete;
   logic                    launch;
   logic                    phase_done;

   generate
      if (lg_credit_to_token_decimation_p == 0) begin : g_no_acc
         assign complete = credit_v_i;
      end else begin : g_acc
         logic [lg_credit_to_token_decimation_p-1:0] acc_r;

         always_ff @(posedge clk_i) begin
            if (reset_i)
               acc_r <= '0;
            else if (credit_v_i)
               acc_r <= acc_r + 1'b1;
         end

         // Wrap from all-ones back to zero completes a token.
         assign complete = credit_v_i & (&acc_r);
      end
   endgenerate

   always_comb begin
      phase_done = (cnt_r == cnt_width_lp'(min_half_period_p));
      launch     = (pend_r != '0)
                   && ((state_r == idle_s) || ((state_r == low_s) && phase_done));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= idle_s;
         token_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            idle_s: begin
               if (launch) begin
                  state_r <= high_s;
                  token_r <= 1'b1;
                  cnt_r   <= cnt_width_lp'(1);
               end
            end
            high_s: begin
               if (phase_done) begin
                  state_r <= low_s;
                  token_r <= 1'b0;
                  cnt_r   <= cnt_width_lp'(1);
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            low_s: begin
               if (phase_done) begin
                  if (launch) begin
                     state_r <= high_s;
                     token_r <= 1'b1;
                     cnt_r   <= cnt_width_lp'(1);
                  end else begin
                     state_r <= idle_s;
                  end
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            default: begin
               state_r <= idle_s;
               token_r <= 1'b0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pend_r     <= ptr_width_lp'(extra_tokens_p);
         overflow_r <= 1'b0;
      end else begin
         case ({complete, launch})
            2'b10: begin
               // A token completing into a full counter is dropped, not wrapped.
               if (pend_r == ptr_width_lp'(max_tokens_lp))
                  overflow_r <= 1'b1;
               else
                  pend_r <= pend_r + 1'b1;
            end
            2'b01:   pend_r <= pend_r - 1'b1;
            default: pend_r <= pend_r;
         endcase
      end
   end

   assign token_o          = token_r;
   assign tokens_pending_o = pend_r;
   assign overflow_o       = overflow_r;

endmodule

// File: tb/tb_bsg_credit_to_token_pacer.sv
// Directed bench for bsg_credit_to_token_pacer; four instances cover the
// decimated, margin-token, overflow and simultaneous complete/launch configurations.
module tb_bsg_credit_to_token_pacer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic       reset_a = 1'b1, credit_a = 1'b0, token_a, ovf_a;
   logic [4:0] pend_a;
   logic       reset_m = 1'b1, credit_m = 1'b0, token_m, ovf_m;
   logic [4:0] pend_m;
   logic       reset_o = 1'b1, credit_o = 1'b0, token_o, ovf_o;
   logic [1:0] pend_o;
   logic       reset_s = 1'b1, credit_s = 1'b0, token_s, ovf_s;
   logic [6:0] pend_s;

   bsg_credit_to_token_pacer #(.lg_credit_to_token_decimation_p(2), .max_credits_p(64),
                               .extra_tokens_p(0), .min_half_period_p(2)) u_a
     (.clk_i(clk), .reset_i(reset_a), .credit_v_i(credit_a), .token_o(token_a),
      .tokens_pending_o(pend_a), .overflow_o(ovf_a));

   bsg_credit_to_token_pacer #(.lg_credit_to_token_decimation_p(2), .max_credits_p(64),
                               .extra_tokens_p(2), .min_half_period_p(1)) u_m
     (.clk_i(clk), .reset_i(reset_m), .credit_v_i(credit_m), .token_o(token_m),
      .tokens_pending_o(pend_m), .overflow_o(ovf_m));

   bsg_credit_to_token_pacer #(.lg_credit_to_token_decimation_p(0), .max_credits_p(2),
                               .extra_tokens_p(0), .min_half_period_p(8)) u_o
     (.clk_i(clk), .reset_i(reset_o), .credit_v_i(credit_o), .token_o(token_o),
      .tokens_pending_o(pend_o), .overflow_o(ovf_o));

   bsg_credit_to_token_pacer #(.lg_credit_to_token_decimation_p(0), .max_credits_p(64),
                               .extra_tokens_p(0), .min_half_period_p(1)) u_s
     (.clk_i(clk), .reset_i(reset_s), .credit_v_i(credit_s), .token_o(token_s),
      .tokens_pending_o(pend_s), .overflow_o(ovf_s));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] tok, pb;
   int          edges, pmax;
   logic        prev;

   initial begin
      tick();
      tick();
      reset_m = 1'b0;
      reset_o = 1'b0;
      reset_s = 1'b0;

      // Basic token: credits t0..t3, high t5..t6
      reset_a = 1'b0;
      tok = '0; pb = '0;
      for (int t = 0; t < 16; t++) begin
         credit_a = (t < 4);
         tok[t] = token_a;
         pb[t]  = (pend_a != '0);
         if (t == 0) check("basic_reset_token", {31'd0, token_a}, 32'd0);
         if (t == 4) check("basic_pend_t4", {27'd0, pend_a}, 32'd1);
         tick();
      end
      check("basic_token_map", tok, 32'h0000_0060);
      check("basic_pend_map", pb, 32'h0000_0010);
      check("basic_overflow", {31'd0, ovf_a}, 32'd0);

      // Back-to-back: 12 credits -> three edges at t5, t9, t13
      reset_a = 1'b1; credit_a = 1'b0; tick(); reset_a = 1'b0;
      tok = '0; pb = '0; edges = 0; prev = 1'b0;
      for (int t = 0; t < 24; t++) begin
         credit_a = (t < 12);
         tok[t] = token_a;
         pb[t]  = (pend_a != '0);
         if (token_a && !prev) edges++;
         prev = token_a;
         tick();
      end
      check("b2b_token_map", tok, 32'h0000_6660);
      check("b2b_pend_map", pb, 32'h0000_1110);
      check("b2b_edges", edges, 32'd3);
      check("b2b_final_pend", {27'd0, pend_a}, 32'd0);

      // Margin tokens: pend 2 after reset, pulses at t1 and t3
      reset_m = 1'b1; tick(); reset_m = 1'b0;
      tok = '0;
      for (int t = 0; t < 16; t++) begin
         tok[t] = token_m;
         if (t == 0) check("margin_pend_reset", {27'd0, pend_m}, 32'd2);
         tick();
      end
      check("margin_token_map", tok, 32'h0000_000A);
      check("margin_final_pend", {27'd0, pend_m}, 32'd0);

      // Overflow: credit each cycle t0..t5, drops at t3..t5
      reset_o = 1'b1; tick(); reset_o = 1'b0;
      edges = 0; prev = 1'b0; pmax = 0;
      for (int t = 0; t < 64; t++) begin
         credit_o = (t < 6);
         if (token_o && !prev) edges++;
         prev = token_o;
         if (int'(pend_o) > pmax) pmax = int'(pend_o);
         if (t == 3) check("ovf_before_drop", {31'd0, ovf_o}, 32'd0);
         if (t == 4) check("ovf_rise", {31'd0, ovf_o}, 32'd1);
         if (t == 5) check("ovf_pend_sat", {30'd0, pend_o}, 32'd2);
         if (t == 9) check("ovf_high_last", {31'd0, token_o}, 32'd1);
         if (t == 10) check("ovf_low_first", {31'd0, token_o}, 32'd0);
         tick();
      end
      check("ovf_sticky", {31'd0, ovf_o}, 32'd1);
      check("ovf_pend_max", pmax, 32'd2);
      check("ovf_edges", edges, 32'd3);
      check("ovf_final_pend", {30'd0, pend_o}, 32'd0);

      // Simultaneous complete and launch: credits t0,t1; pulses t2,t4
      reset_s = 1'b1; tick(); reset_s = 1'b0;
      tok = '0;
      for (int t = 0; t < 12; t++) begin
         credit_s = (t < 2);
         tok[t] = token_s;
         if (t == 2) check("simul_pend_hold", {25'd0, pend_s}, 32'd1);
         tick();
      end
      check("simul_token_map", tok, 32'h0000_0014);
      check("simul_final_pend", {25'd0, pend_s}, 32'd0);

      // Reset mid-HIGH at t5 with a credit under reset; acc must restart
      reset_a = 1'b1; credit_a = 1'b0; tick(); reset_a = 1'b0;
      tok = '0; pb = '0;
      for (int t = 0; t < 20; t++) begin
         credit_a = (t < 10);
         reset_a  = (t == 5);
         tok[t] = token_a;
         pb[t]  = (pend_a != '0);
         tick();
      end
      reset_a = 1'b0;
      check("rst_token_map", tok, 32'h0000_1820);
      check("rst_pend_map", pb, 32'h0000_0410);
      check("rst_overflow", {31'd0, ovf_a}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bsg_credit_to_token_pacer.md
# bsg_credit_to_token_pacer

Receive-side credit return stage that sits directly upstream of `bsg_async_credit_counter`. It accumulates freed-buffer credits, one per `credit_v_i` pulse. Every 2^`lg_credit_to_token_decimation_p` credits it emits one token, as a paced rising edge on `token_o`. `token_o` drives the counter's `w_clk_i` (with `w_inc_token_i` tied high), so its high and low phases are held for a minimum number of cycles to bound the toggle rate on the off-chip pin.

## Interface
Parameters:
- `lg_credit_to_token_decimation_p`, default 3: log2 of credits per token; 0 means one token per credit.
- `max_credits_p`, default 64: maximum credits that may be outstanding (not yet returned); must be a multiple of 2^lg.
- `extra_tokens_p`, default 0: margin tokens emitted after reset before any credit arrives.
- `min_half_period_p`, default 2: minimum cycles `token_o` stays high and then low per token; must be ≥1.

Derived width:
- `max_tokens_lp` = (`max_credits_p` >> lg) + `extra_tokens_p`.
- `ptr_width_lp` = $clog2(`max_tokens_lp`+1).

Ports:
- `clk_i` input 1: single clock.
- `reset_i` input 1: synchronous, active-high reset.
- `credit_v_i` input 1: one credit freed this cycle.
- `token_o` output 1: registered token level; each 0→1 edge is one token.
- `tokens_pending_o` output `ptr_width_lp`: completed tokens not yet launched.
- `overflow_o` output 1: sticky error; a token completed while pending was at `max_tokens_lp`.

## Operation
Credit accumulator `acc_r`:
- Width lg; absent when lg=0.
- On `credit_v_i`, increments with wrap.
- Wrap from all-ones to 0 is a "token complete" event. When lg=0, every `credit_v_i` is a token-complete event.

Pending counter `pend_r`:
- +1 on token complete; −1 on launch.
- Simultaneous complete and launch: value unchanged.
- Complete while `pend_r`=`max_tokens_lp` with no launch: token dropped, `pend_r` saturates, `overflow_o` set until reset.

Pacing FSM, with phase counter `cnt_r` ($clog2(`min_half_period_p`+1) bits):
- **IDLE** (`token_o`=0): if `pend_r`≠0, launch (decrement `pend_r`), go to HIGH, `cnt_r`=1.
- **HIGH** (`token_o`=1): if `cnt_r`=`min_half_period_p`, go to LOW with `cnt_r`=1; else `cnt_r`++.
- **LOW** (`token_o`=0): if `cnt_r`=`min_half_period_p`:
  - if `pend_r`≠0, launch and go to HIGH with `cnt_r`=1;
  - else go to IDLE.
  - Otherwise `cnt_r`++.
- The launch decision uses the registered `pend_r`. A token completing in the same cycle is not seen until the next cycle.

Reset values (in effect the cycle after `reset_i` is sampled high):
- `token_o`=0, state IDLE, `acc_r`=0, `cnt_r`=0.
- `pend_r`=`extra_tokens_p`, `overflow_o`=0.

Reset behaviour:
- Reset mid-HIGH truncates the pulse: `token_o` is 0 in the next cycle. The paired counter is reset under the same procedure, so no token accounting is preserved.
- `credit_v_i` is ignored while `reset_i`=1.

Arithmetic:
- All counters are unsigned.
- `tokens_pending_o` is `pend_r` directly, a registered output.

## Timing
- Token latency: a credit completing a token in cycle t gives `pend_r`=1 in t+1. From IDLE, `token_o`=1 in t+2.
- High phase is exactly `min_half_period_p` cycles. Low phase is ≥`min_half_period_p` cycles.
- Back-to-back tokens have a period of exactly 2·`min_half_period_p` cycles.
- Sustained throughput without growth of `pend_r` requires average credit rate ≤ 2^lg / (2·`min_half_period_p`) per cycle. Excess credits accumulate in `pend_r`.
- `overflow_o` rises the cycle after the dropping event.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Basic token.** Parameters lg=2, half=2; after reset, `credit_v_i`=1 for 4 cycles (t0..t3). Expect `token_o` high in t5–t6, low from t7; `pend_r` is 1 only in t4; `overflow_o`=0.
- **Back-to-back tokens.** Parameters lg=2, half=2; 12 consecutive credits. Expect exactly 3 rising edges spaced 4 cycles apart, then IDLE with `tokens_pending_o`=0.
- **Margin tokens.** Parameters `extra_tokens_p`=2, half=1; reset then no credits. Expect `tokens_pending_o`=2 after reset, and two pulses: high, low, high, low on consecutive cycles. Then `token_o`=0 permanently.
- **Overflow.** Parameters lg=0, `max_credits_p`=2, half=8; credit every cycle for 6 cycles. Expect `tokens_pending_o` to saturate at 2, `overflow_o`=1 and sticky, and only the non-dropped tokens emitted.
- **Simultaneous complete and launch.** Parameters lg=0, half=1; pending=1, with a credit arriving in the launch cycle. Expect `pend_r` to stay at 1 and the next pulse to follow at period 2.
- **Reset mid-pulse.** Assert `reset_i` during HIGH. Expect `token_o`=0 the next cycle, `acc_r`=0, and `pend_r`=`extra_tokens_p`. A subsequent 2^lg credits yields a normal pulse.
